// File: rtl/moore_seq_detector.sv
// rtl/moore_seq_detector.sv - Moore serial pattern detector with saturating match counter
module moore_seq_detector #(
  parameter int              PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int              CNT_W   = 8,
  localparam int             SW      = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             en,
  input  logic             clr,
  input  logic             overlap,
  output logic             match,
  output logic [SW-1:0]    state,
  output logic [CNT_W-1:0] match_count
);

  // State index k means the first k pattern bits have been seen; k == PAT_W is DETECT.
  // The number of states depends on PAT_W, so states are plain indices rather than enum names.
  localparam logic [SW-1:0]    S_IDLE   = '0;
  localparam logic [SW-1:0]    S_DETECT = SW'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Longest prefix of the pattern that is a suffix of (first k pattern bits, then b).
  // PATTERN[PAT_W-1] is the earliest bit in time.
  function automatic int adv_f(input int k, input int b);
    int  best;
    int  p;
    bit  ok;
    bit  s_bit;
    best = 0;
    for (int j = 1; j <= PAT_W; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int t = 0; t < j; t++) begin
          p = k + 1 - j + t;
          if (p == k) s_bit = b[0];
          else        s_bit = PATTERN[PAT_W-1-p];
          if (PATTERN[PAT_W-1-t] != s_bit) ok = 1'b0;
        end
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  logic [SW-1:0]    adv_tab [PAT_W+1][2];
  logic [SW-1:0]    state_q, state_d;
  logic [SW-1:0]    adv_sel;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Transition table is fixed at elaboration; only the current index is stored at runtime.
  for (genvar k = 0; k <= PAT_W; k++) begin : g_k
    for (genvar b = 0; b < 2; b++) begin : g_b
      localparam logic [SW-1:0] NXT = SW'(adv_f(k, b));
      assign adv_tab[k][b] = NXT;
    end
  end

  // Select the successor for the sampled bit; non-overlap DETECT restarts from an empty history.
  always_comb begin
    adv_sel = S_IDLE;
    for (int k = 0; k <= PAT_W; k++) begin
      if (state_q == SW'(k)) adv_sel = adv_tab[k][din];
    end
    if (state_q == S_DETECT && !overlap) adv_sel = adv_tab[0][din];
  end

  // Next state and counter: clear wins, then enable gates sampling; every DETECT entry counts.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clr) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (en) begin
      state_d = adv_sel;
      if (adv_sel == S_DETECT && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  // State and counter registers; reset drops any partial match immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign match       = (state_q == S_DETECT);
  assign state       = state_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_moore_seq_detector.sv
// tb/tb_moore_seq_detector.sv - self-checking bench for moore_seq_detector
module tb_moore_seq_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, din, en, clr, overlap;
  logic [2:0] state0, state1;
  logic [1:0] state2;
  logic       match0, match1, match2;
  logic [7:0] cnt0, cnt2;
  logic [1:0] cnt1;

  moore_seq_detector dut0 (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clr(clr), .overlap(overlap),
    .match(match0), .state(state0), .match_count(cnt0)
  );

  moore_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clr(clr), .overlap(overlap),
    .match(match1), .state(state1), .match_count(cnt1)
  );

  moore_seq_detector #(.PAT_W(3), .PATTERN(3'b111), .CNT_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clr(clr), .overlap(overlap),
    .match(match2), .state(state2), .match_count(cnt2)
  );

  int n_cmp = 0;
  int n_err = 0;
  int pulses0 = 0;

  // Reference: remember the sampled bits and find the longest pattern prefix ending them.
  int          pw   [3] = '{4, 4, 3};
  logic [15:0] pv   [3] = '{16'h000B, 16'h000B, 16'h0007};
  int          cmax [3] = '{255, 3, 255};
  logic [31:0] hist [3];
  int          hlen [3];
  int          mst  [3];
  int          mcnt [3];

  int obs_st [3];
  int obs_cnt[3];
  int obs_m  [3];
  always_comb begin
    obs_st[0] = int'(state0); obs_st[1] = int'(state1); obs_st[2] = int'(state2);
    obs_cnt[0] = int'(cnt0);  obs_cnt[1] = int'(cnt1);  obs_cnt[2] = int'(cnt2);
    obs_m[0] = int'(match0);  obs_m[1] = int'(match1);  obs_m[2] = int'(match2);
  end

  function automatic int longest(logic [31:0] h, int hl, int w, logic [15:0] p);
    bit ok;
    for (int j = w; j >= 1; j--) begin
      if (j <= hl) begin
        ok = 1'b1;
        for (int t = 0; t < j; t++) if (h[t] !== p[w-j+t]) ok = 1'b0;
        if (ok) return j;
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      hist[i] = '0; hlen[i] = 0; mst[i] = 0; mcnt[i] = 0;
    end
    pulses0 = 0;
  endtask

  task automatic model_edge(input bit b, input bit e, input bit c, input bit o);
    for (int i = 0; i < 3; i++) begin
      if (c) begin
        hist[i] = '0; hlen[i] = 0; mst[i] = 0; mcnt[i] = 0;
      end else if (e) begin
        if (mst[i] == pw[i] && !o) hlen[i] = 0;
        hist[i] = {hist[i][30:0], b};
        if (hlen[i] < 32) hlen[i]++;
        mst[i] = longest(hist[i], hlen[i], pw[i], pv[i]);
        if (mst[i] == pw[i] && mcnt[i] < cmax[i]) mcnt[i]++;
      end
    end
  endtask

  task automatic step(input bit b, input bit e, input bit c, input bit o);
    @(negedge clk);
    din = b; en = e; clr = c; overlap = o;
    @(posedge clk);
    model_edge(b, e, c, o);
    #1;
    if (match0) pulses0++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; din = 1'b0; en = 1'b0; clr = 1'b0; overlap = 1'b1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (state0 !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d expected 0", state0); end
    n_cmp++; if (match0 !== 1'b0) begin n_err++; $display("FAIL reset_match: got %0d expected 0", match0); end
    n_cmp++; if (cnt0 !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", cnt0); end
    @(negedge clk); rst_n = 1'b1;
    step(1, 1, 0, 1); step(0, 1, 0, 1); step(1, 1, 0, 1);
    n_cmp++; if (state0 !== 3'd3) begin n_err++; $display("FAIL pre_reset_state: got %0d expected 3", state0); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (state0 !== 3'd0) begin n_err++; $display("FAIL async_reset_state: got %0d expected 0", state0); end
    n_cmp++; if (match0 !== 1'b0) begin n_err++; $display("FAIL async_reset_match: got %0d expected 0", match0); end
    n_cmp++; if (cnt0 !== 8'd0) begin n_err++; $display("FAIL async_reset_count: got %0d expected 0", cnt0); end
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    step(1, 1, 0, 1); step(0, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1); step(0, 1, 0, 1);
    n_cmp++; if (pulses0 !== 1) begin n_err++; $display("FAIL post_reset_pulses: got %0d expected 1", pulses0); end
    n_cmp++; if (cnt0 !== 8'd1) begin n_err++; $display("FAIL post_reset_count: got %0d expected 1", cnt0); end
  endtask

  task automatic test_basic();
    bit b_seq [4] = '{1, 0, 1, 1};
    int s_exp [4] = '{1, 2, 3, 4};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(b_seq[i], 1, 0, 1);
      n_cmp++; if (int'(state0) !== s_exp[i]) begin n_err++; $display("FAIL basic_state[%0d]: got %0d expected %0d", i, state0, s_exp[i]); end
      n_cmp++; if (match0 !== (i == 3)) begin n_err++; $display("FAIL basic_match[%0d]: got %0d expected %0d", i, match0, i == 3); end
    end
    n_cmp++; if (cnt0 !== 8'd1) begin n_err++; $display("FAIL basic_count: got %0d expected 1", cnt0); end
    step(0, 1, 0, 1);
    n_cmp++; if (match0 !== 1'b0) begin n_err++; $display("FAIL basic_match_drop: got %0d expected 0", match0); end
  endtask

  task automatic test_overlap();
    bit b_seq [7] = '{1, 0, 1, 1, 0, 1, 1};
    for (int o = 1; o >= 0; o--) begin
      do_reset();
      for (int i = 0; i < 7; i++) begin
        step(b_seq[i], 1, 0, o[0]);
        if (i == 4) begin
          n_cmp++;
          if (int'(state0) !== (o == 1 ? 2 : 0)) begin n_err++; $display("FAIL ovl%0d_state5: got %0d expected %0d", o, state0, o == 1 ? 2 : 0); end
        end
      end
      n_cmp++; if (int'(state0) !== (o == 1 ? 4 : 1)) begin n_err++; $display("FAIL ovl%0d_final_state: got %0d expected %0d", o, state0, o == 1 ? 4 : 1); end
      n_cmp++; if (int'(cnt0) !== (o == 1 ? 2 : 1)) begin n_err++; $display("FAIL ovl%0d_count: got %0d expected %0d", o, cnt0, o == 1 ? 2 : 1); end
      n_cmp++; if (pulses0 !== (o == 1 ? 2 : 1)) begin n_err++; $display("FAIL ovl%0d_pulses: got %0d expected %0d", o, pulses0, o == 1 ? 2 : 1); end
    end
  endtask

  task automatic test_enable();
    do_reset();
    step(1, 1, 0, 1); step(0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step(i[0], 0, 0, 1);
      n_cmp++; if (state0 !== 3'd2) begin n_err++; $display("FAIL gap_state[%0d]: got %0d expected 2", i, state0); end
    end
    step(1, 1, 0, 1); step(1, 1, 0, 1);
    n_cmp++; if (match0 !== 1'b1) begin n_err++; $display("FAIL enable_match: got %0d expected 1", match0); end
    step(0, 0, 0, 1);
    n_cmp++; if (match0 !== 1'b1) begin n_err++; $display("FAIL enable_match_hold: got %0d expected 1", match0); end
    n_cmp++; if (cnt0 !== 8'd1) begin n_err++; $display("FAIL enable_count: got %0d expected 1", cnt0); end
  endtask

  task automatic test_saturate_clear();
    int c_exp [5] = '{1, 2, 3, 3, 3};
    do_reset();
    for (int m = 0; m < 5; m++) begin
      step(1, 1, 0, 0); step(0, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
      n_cmp++; if (int'(cnt1) !== c_exp[m]) begin n_err++; $display("FAIL sat_count[%0d]: got %0d expected %0d", m, cnt1, c_exp[m]); end
    end
    step(1, 1, 0, 0); step(0, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 1, 0);
    n_cmp++; if (state1 !== 3'd0) begin n_err++; $display("FAIL clr_state: got %0d expected 0", state1); end
    n_cmp++; if (cnt1 !== 2'd0) begin n_err++; $display("FAIL clr_count: got %0d expected 0", cnt1); end
    n_cmp++; if (match1 !== 1'b0) begin n_err++; $display("FAIL clr_match: got %0d expected 0", match1); end
  endtask

  task automatic test_alt_pattern();
    int s_exp [5] = '{1, 2, 3, 3, 3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 0, 1);
      n_cmp++; if (int'(state2) !== s_exp[i]) begin n_err++; $display("FAIL alt_state[%0d]: got %0d expected %0d", i, state2, s_exp[i]); end
      n_cmp++; if (match2 !== (i >= 2)) begin n_err++; $display("FAIL alt_match[%0d]: got %0d expected %0d", i, match2, i >= 2); end
    end
    n_cmp++; if (cnt2 !== 8'd3) begin n_err++; $display("FAIL alt_count: got %0d expected 3", cnt2); end
  endtask

  task automatic test_random();
    bit b, e, c, o;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      b = $urandom_range(0, 1) == 1;
      e = $urandom_range(0, 9) < 8;
      c = $urandom_range(0, 99) < 3;
      o = $urandom_range(0, 1) == 1;
      step(b, e, c, o);
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (obs_st[i] !== mst[i]) begin n_err++; $display("FAIL rnd_state dut%0d cyc%0d: got %0d expected %0d", i, n, obs_st[i], mst[i]); end
        n_cmp++; if (obs_m[i] !== int'(mst[i] == pw[i])) begin n_err++; $display("FAIL rnd_match dut%0d cyc%0d: got %0d expected %0d", i, n, obs_m[i], mst[i] == pw[i]); end
        n_cmp++; if (obs_cnt[i] !== mcnt[i]) begin n_err++; $display("FAIL rnd_count dut%0d cyc%0d: got %0d expected %0d", i, n, obs_cnt[i], mcnt[i]); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; en = 1'b0; clr = 1'b0; overlap = 1'b1;
    model_reset();
    test_reset();
    test_basic();
    test_overlap();
    test_enable();
    test_saturate_clear();
    test_alt_pattern();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/moore_seq_detector.md
# moore_seq_detector

Moore-type serial sequence detector that consumes the registered single-bit stream produced by the input D flip-flop stage (its `q` output) and flags every occurrence of a fixed bit pattern. Sits directly downstream of that flop inside the Tiny Tapeout user design; its outputs drive `uo_out` bits in the top-level wrapper. Counts matches in a saturating counter and exposes the current state for debug.

## Interface

Parameters:
- `PAT_W`, 4, pattern length in bits; legal range 2..16.
- `PATTERN`, 4'b1011, pattern to detect; `PATTERN[PAT_W-1]` is the first bit expected in time, `PATTERN[0]` the last.
- `CNT_W`, 8, width of the match counter; legal range 2..16.

Ports (`SW = $clog2(PAT_W+1)`):
- `clk`  input  1  clock.
- `rst_n`  input  1  reset: asynchronous, active-low.
- `din`  input  1  serial data bit, registered output of the upstream flop.
- `en`  input  1  sample enable; `din` is consumed only on edges where `en`=1.
- `clr`  input  1  synchronous clear of state and counter.
- `overlap`  input  1  1 = overlapping detection, 0 = non-overlapping.
- `match`  output  1  Moore output, high while in state DETECT.
- `state`  output  SW  current state index, 0..PAT_W.
- `match_count`  output  CNT_W  number of DETECT entries since reset/clear, saturating.

## Operation

- States S0..S(PAT_W); Sk = first k pattern bits matched; S(PAT_W) = DETECT.
- Define `adv(k, b)`: longest j ≤ PAT_W such that the first j pattern bits equal a suffix of (first k pattern bits followed by b). Computed at elaboration from `PATTERN`; no runtime pattern storage.
- From Sk, k < PAT_W, on sampled bit b: next = S(adv(k, b)).
- From DETECT, `overlap`=1: next = S(adv(PAT_W, b)) restricted to j < PAT_W unless the full pattern again matches (i.e., longest proper border plus b; may reach DETECT again if pattern permits).
- From DETECT, `overlap`=0: next = S(adv(0, b)); history discarded.
- `overlap` sampled on the same edge as `din`; may change any cycle.
- `match` = (state == PAT_W); derived from state register only, never from `din`.
- `match_count` increments by 1 on every edge that enters DETECT (including DETECT→DETECT re-entry); holds at 2^CNT_W−1 once reached.
- `en`=0: state and counter hold; `match` holds its value.
- `clr`=1: state → S0, `match_count` → 0 on next edge; overrides `en` and any increment in the same cycle.
- Reset values: `state`=0, `match`=0, `match_count`=0.

## Timing

- All outputs registered; state and counter update on posedge `clk`.
- `match` rises in the cycle immediately after the edge that sampled the final pattern bit; stays high exactly one cycle per match when `en` stays high and the next bit does not complete another match.
- End-to-end from top-level `ui_in[0]`: 2 cycles (1 in upstream flop, 1 here).
- `match_count` updates on the same edge `match` rises.
- `rst_n` low asserts immediately, independent of `clk`, mid-sequence included; partial match discarded. Release is synchronised upstream in the wrapper; first sample on first edge after release.

## Test plan

- Reset mid-sequence: feed 1,0,1 then pulse `rst_n` low → `state`=0, `match`=0, `match_count`=0 immediately; subsequent 1,0,1,1 → single `match` pulse, count=1.
- Basic detect (`PATTERN`=1011, `overlap`=1, `en`=1): din 1,0,1,1 → `state` 1,2,3,4; `match`=1 one cycle after 4th bit; count=1.
- Overlap vs non-overlap: din 1,0,1,1,0,1,1 → `overlap`=1 gives two `match` pulses (count=2, state after 5th bit = 2); `overlap`=0 gives one pulse (count=1, state ends at 1).
- Enable gating: 1,0 with `en`=1, then 3 cycles `en`=0 with din toggling, then 1,1 with `en`=1 → exactly one match; state frozen at 2 during the gap.
- Saturation and clear (`CNT_W`=2): 5 complete non-overlapping matches → count sequence 1,2,3,3,3; then `clr`=1 together with the edge completing a 6th match → state=0, count=0, `match`=0.
- Alternate pattern (`PAT_W`=3, `PATTERN`=3'b111, `overlap`=1): din 1,1,1,1,1 → `match` high on 3 consecutive cycles, count=3.
